gshare_predictor: RTL and testbench

Direction predictor and next-PC selector for the 5-stage RISC-V pipeline. It sits directly downstream of the BTB. The BTB supplies a tag hit and target for the fetch PC. This block adds a 2-bit saturating-counter pattern history table (PHT), indexed gshare-style, and decides the fetch `next_pc`. It is trained and checked at branch resolution in EX, where it raises the mispredict/redirect used to flush IF/ID.

---
 rtl/gshare_predictor_pkg.sv | 29 ++
 rtl/gshare_predictor_if.sv | 49 ++++
 rtl/gshare_predictor_sat_counter2.sv | 32 +++
 rtl/gshare_predictor.sv | 96 +++++++++
 tb/tb_gshare_predictor.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gshare_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_pkg
// Description : Shared types and constants for the gshare direction predictor:
//               2-bit counter encodings, counter reset value, default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package gshare_predictor_pkg;

    typedef logic [1:0] ctr_t;

    // Two-bit saturating counter encodings
    localparam ctr_t CTR_SNT   = 2'b00;  // strongly not-taken
    localparam ctr_t CTR_WNT   = 2'b01;  // weakly not-taken
    localparam ctr_t CTR_WT    = 2'b10;  // weakly taken
    localparam ctr_t CTR_ST    = 2'b11;  // strongly taken
    localparam ctr_t CTR_RESET = CTR_WNT;

    // Default widths
    localparam int PHT_IDX_W_DEF = 5;
    localparam int GHR_W_DEF     = 5;

    // Direction encoded by a counter: its MSB
    function automatic logic ctr_taken(input ctr_t ctr);
        return ctr[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor_if
// Description : Fetch-side and EX-side signal bundle of the gshare predictor.
//               master = pipeline driving it, slave = predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface gshare_predictor_if
    import gshare_predictor_pkg::*;
#(
    parameter int PHT_IDX_W = PHT_IDX_W_DEF
);
    // Fetch side
    logic [31:0]          if_pc;
    logic                 btb_hit;
    logic [31:0]          btb_target;
    logic [31:0]          next_pc;
    logic                 pred_taken;
    logic [PHT_IDX_W-1:0] pred_idx;

    // EX resolution side
    logic                 ex_valid;
    logic                 ex_branch;
    logic                 ex_is_jal;
    logic                 ex_is_jalr;
    logic                 ex_taken;
    logic [31:0]          ex_pc;
    logic [31:0]          ex_target;
    logic [31:0]          ex_pred_next_pc;
    logic [PHT_IDX_W-1:0] ex_pred_idx;
    logic                 mispredict;
    logic [31:0]          redirect_pc;

    modport master (
        output if_pc, btb_hit, btb_target,
        output ex_valid, ex_branch, ex_is_jal, ex_is_jalr, ex_taken,
        output ex_pc, ex_target, ex_pred_next_pc, ex_pred_idx,
        input  next_pc, pred_taken, pred_idx, mispredict, redirect_pc
    );

    modport slave (
        input  if_pc, btb_hit, btb_target,
        input  ex_valid, ex_branch, ex_is_jal, ex_is_jalr, ex_taken,
        input  ex_pc, ex_target, ex_pred_next_pc, ex_pred_idx,
        output next_pc, pred_taken, pred_idx, mispredict, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/gshare_predictor_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter2
// Description : Pure next-value function of a 2-bit saturating counter.
//               inc has priority if both requests are raised.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import gshare_predictor_pkg::*;
(
    input  wire ctr_t cur,
    input  wire logic inc,
    input  wire logic dec,
    output ctr_t      next_val
);

    // Step toward the requested direction, holding at either end
    always_comb begin
        next_val = cur;
        if (inc) begin
            if (cur != CTR_ST) begin
                next_val = cur + 2'd1;
            end
        end else if (dec) begin
            if (cur != CTR_SNT) begin
                next_val = cur - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_predictor
// Description : 2-bit counter PHT direction predictor and next-PC selector,
//               trained non-speculatively at EX resolution.
//               Optional macro GSHARE_XOR_EN: defined -> PC bits XOR global
//               history index (GHR present); undefined -> bimodal, no GHR.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int GHR_W     = GHR_W_DEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    gshare_predictor_if.slave bus
);

    localparam int PHT_DEPTH = 1 << PHT_IDX_W;

    ctr_t                 r_pht [PHT_DEPTH];
    logic [PHT_IDX_W-1:0] w_raw_idx;
    logic [PHT_IDX_W-1:0] w_pred_idx;
    ctr_t                 w_pred_ctr;
    ctr_t                 w_train_cur;
    ctr_t                 w_train_next;
    logic                 w_train_inc;
    logic                 w_train_dec;
    logic                 w_is_ctrl;
    logic                 w_goes_target;
    logic [31:0]          w_actual_next;

    // Word-aligned PC bits select the counter
    assign w_raw_idx = bus.if_pc[PHT_IDX_W+1:2];

`ifdef GSHARE_XOR_EN
    logic [GHR_W-1:0] r_ghr;

    assign w_pred_idx = w_raw_idx ^ PHT_IDX_W'(r_ghr);

    // Committed history: shift in each resolved conditional-branch outcome
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (bus.ex_valid && bus.ex_branch) begin
            r_ghr <= (r_ghr << 1) | GHR_W'(bus.ex_taken);
        end
    end
`else
    logic w_unused_ghr_cfg;

    assign w_pred_idx       = w_raw_idx;
    assign w_unused_ghr_cfg = (GHR_W > PHT_IDX_W);
`endif

    // Fetch-side prediction (read returns the pre-update value, no bypass)
    assign w_pred_ctr     = r_pht[w_pred_idx];
    assign bus.pred_idx   = w_pred_idx;
    assign bus.pred_taken = ctr_taken(w_pred_ctr);
    assign bus.next_pc    = (bus.btb_hit && ctr_taken(w_pred_ctr)) ? bus.btb_target
                                                                   : bus.if_pc + 32'd4;

    // EX-side resolution
    assign w_is_ctrl       = bus.ex_branch | bus.ex_is_jal | bus.ex_is_jalr;
    assign w_goes_target   = bus.ex_is_jal | bus.ex_is_jalr | (bus.ex_branch & bus.ex_taken);
    assign w_actual_next   = w_goes_target ? bus.ex_target : bus.ex_pc + 32'd4;
    assign bus.redirect_pc = w_actual_next;
    assign bus.mispredict  = bus.ex_valid & w_is_ctrl & (w_actual_next != bus.ex_pred_next_pc);

    // Branches move toward their outcome; jumps always count as taken
    assign w_train_inc = bus.ex_branch ? bus.ex_taken : (bus.ex_is_jal | bus.ex_is_jalr);
    assign w_train_dec = bus.ex_branch & ~bus.ex_taken;
    assign w_train_cur = r_pht[bus.ex_pred_idx];

    sat_counter2 u_train_ctr (
        .cur      (w_train_cur),
        .inc      (w_train_inc),
        .dec      (w_train_dec),
        .next_val (w_train_next)
    );

    // PHT storage: reset loop has priority over a same-edge training write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= CTR_RESET;
            end
        end else if (bus.ex_valid && (w_train_inc || w_train_dec)) begin
            r_pht[bus.ex_pred_idx] <= w_train_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_predictor
// Description : Self-checking bench for gshare_predictor (PHT_IDX_W=5,
//               GHR_W=5). Honours GSHARE_XOR_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic reset;

    gshare_predictor_if #(.PHT_IDX_W(5)) bus ();

    gshare_predictor #(
        .PHT_IDX_W (5),
        .GHR_W     (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: counters as plain integers 0..3, history as integer
    int m_pht [32];
    int m_ghr;
    bit m_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_idx(input logic [31:0] pc);
        int raw;
        raw = int'((pc >> 2) & 32'h1f);
`ifdef GSHARE_XOR_EN
        raw = raw ^ m_ghr;
`endif
        return raw;
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic hit,
                                                  input logic [31:0] tgt);
        if (hit && m_pht[model_idx(pc)] >= 2) return tgt;
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] model_actual_next();
        if (bus.ex_is_jal || bus.ex_is_jalr || (bus.ex_branch && bus.ex_taken))
            return bus.ex_target;
        return bus.ex_pc + 32'd4;
    endfunction

    function automatic logic model_mispredict();
        if (!bus.ex_valid) return 1'b0;
        if (!(bus.ex_branch || bus.ex_is_jal || bus.ex_is_jalr)) return 1'b0;
        return model_actual_next() != bus.ex_pred_next_pc;
    endfunction

    // Model state follows the training rules on each rising edge
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_pht[i] <= 1;
            m_ghr   <= 0;
            m_valid <= 1'b1;
        end else if (bus.ex_valid) begin
            if (bus.ex_branch) begin
                if (bus.ex_taken)
                    m_pht[bus.ex_pred_idx] <= (m_pht[bus.ex_pred_idx] == 3) ? 3 : m_pht[bus.ex_pred_idx] + 1;
                else
                    m_pht[bus.ex_pred_idx] <= (m_pht[bus.ex_pred_idx] == 0) ? 0 : m_pht[bus.ex_pred_idx] - 1;
                m_ghr <= ((m_ghr << 1) | int'(bus.ex_taken)) & 31;
            end else if (bus.ex_is_jal || bus.ex_is_jalr) begin
                m_pht[bus.ex_pred_idx] <= (m_pht[bus.ex_pred_idx] == 3) ? 3 : m_pht[bus.ex_pred_idx] + 1;
            end
        end
    end

    // Every falling edge: all outputs against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_pred_idx", 32'(bus.pred_idx), 32'(model_idx(bus.if_pc)));
            check("cyc_pred_taken", 32'(bus.pred_taken), 32'(m_pht[model_idx(bus.if_pc)] >= 2));
            check("cyc_next_pc", bus.next_pc, model_next_pc(bus.if_pc, bus.btb_hit, bus.btb_target));
            check("cyc_mispredict", 32'(bus.mispredict), 32'(model_mispredict()));
            check("cyc_redirect_pc", bus.redirect_pc, model_actual_next());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        bus.if_pc      = pc;
        bus.btb_hit    = hit;
        bus.btb_target = tgt;
    endtask

    task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                          input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic [31:0] pnext, input logic [4:0] idx);
        bus.ex_valid        = v;
        bus.ex_branch       = br;
        bus.ex_is_jal       = jal;
        bus.ex_is_jalr      = jalr;
        bus.ex_taken        = tk;
        bus.ex_pc           = pc;
        bus.ex_target       = tgt;
        bus.ex_pred_next_pc = pnext;
        bus.ex_pred_idx     = idx;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'h0);
    endtask

    // Directed sequence with hand-computed literal expectations
    initial begin
        reset = 1'b1;
        fetch(32'h0, 1'b0, 32'h0);
        idle();
        tick();
        tick();
        reset = 1'b0;

        // Reset state: weakly not-taken everywhere, GHR zero
        fetch(32'h40, 1'b1, 32'h100);
        #1;
        check("rst_pred_taken", 32'(bus.pred_taken), 32'h0);
        check("rst_next_pc", bus.next_pc, 32'h44);
        check("rst_pred_idx", 32'(bus.pred_idx), 32'h10);

        // Two taken resolves at index 0x10: 01 -> 10 -> 11
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h44, 5'h10);
        tick();
        tick();
        idle();
        #1;
`ifdef GSHARE_XOR_EN
        check("train_pred_idx", 32'(bus.pred_idx), 32'h13);
        check("train_next_pc", bus.next_pc, 32'h44);
`else
        check("train_pred_taken", 32'(bus.pred_taken), 32'h1);
        check("train_next_pc", bus.next_pc, 32'h100);
`endif

        // Saturation at 11, then one and two not-taken steps
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h100, 5'h10);
        tick();
        tick();
        tick();
        idle();
        #1;
`ifdef GSHARE_XOR_EN
        check("sat_pred_idx", 32'(bus.pred_idx), 32'h0f);
`else
        check("sat_pred_taken", 32'(bus.pred_taken), 32'h1);
`endif
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h100, 5'h10);
        tick();
        idle();
        #1;
`ifdef GSHARE_XOR_EN
        check("nt1_pred_idx", 32'(bus.pred_idx), 32'h0e);
`else
        check("nt1_pred_taken", 32'(bus.pred_taken), 32'h1);
        check("nt1_next_pc", bus.next_pc, 32'h100);
`endif
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h100, 5'h10);
        tick();
        idle();
        #1;
`ifdef GSHARE_XOR_EN
        check("nt2_pred_idx", 32'(bus.pred_idx), 32'h0c);
`else
        check("nt2_pred_taken", 32'(bus.pred_taken), 32'h0);
        check("nt2_next_pc", bus.next_pc, 32'h44);
`endif

        // Resolution path, combinational
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h100, 5'h10);
        #1;
        check("mp_branch_mispredict", 32'(bus.mispredict), 32'h1);
        check("mp_branch_redirect", bus.redirect_pc, 32'h44);
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h200, 32'h200, 5'h10);
        #1;
        check("mp_jal_mispredict", 32'(bus.mispredict), 32'h0);
        check("mp_jal_redirect", bus.redirect_pc, 32'h200);
        set_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h100, 5'h10);
        #1;
        check("mp_invalid_mispredict", 32'(bus.mispredict), 32'h0);
        tick();
        set_ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h100, 5'h10);
        #1;
        check("mp_nonctrl_mispredict", 32'(bus.mispredict), 32'h0);
        fetch(32'hFFFF_FFFC, 1'b0, 32'h0);
        #1;
        check("wrap_next_pc", bus.next_pc, 32'h0);
        idle();
        tick();

        // History: taken, taken, not-taken -> 00110; a jal leaves it alone
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h44, 5'h10);
        tick();
        tick();
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h100, 32'h100, 5'h10);
        tick();
        idle();
        fetch(32'h40, 1'b1, 32'h100);
        #1;
`ifdef GSHARE_XOR_EN
        check("ghr_pred_idx", 32'(bus.pred_idx), 32'h16);
`else
        check("ghr_pred_idx", 32'(bus.pred_idx), 32'h10);
`endif
        set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h200, 32'h200, 5'h05);
        tick();
        idle();
        #1;
`ifdef GSHARE_XOR_EN
        check("jal_ghr_pred_idx", 32'(bus.pred_idx), 32'h16);
`else
        check("jal_ghr_pred_idx", 32'(bus.pred_idx), 32'h10);
`endif

        // Reset beats a simultaneous taken resolve on a saturated counter
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h100, 5'h10);
        tick();
        tick();
        tick();
        idle();
        #1;
`ifndef GSHARE_XOR_EN
        check("pre_rst_pred_taken", 32'(bus.pred_taken), 32'h1);
`endif
        set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h100, 32'h100, 5'h10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        fetch(32'h40, 1'b1, 32'h100);
        #1;
        check("rst_win_pred_taken", 32'(bus.pred_taken), 32'h0);
        check("rst_win_pred_idx", 32'(bus.pred_idx), 32'h10);
        check("rst_win_next_pc", bus.next_pc, 32'h44);

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
